// File: rtl/skeleton_pass_scheduler_pkg.sv
// Shared types and width helpers for the skeleton thinning pass scheduler.
// The FSM state encodings mirror the phase_t enum values.
package skeleton_pass_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        DECIDE = 3'd3,
        OUTPUT = 3'd4
    } phase_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_width(input int h, input int v);
        return cnt_width(h * v);
    endfunction

endpackage

// File: rtl/skeleton_pass_scheduler_if.sv
// Control/status bundle between the pass scheduler (master) and the frame
// loader / thinning datapath / read-out consumer (slave).
interface skeleton_pass_scheduler_if
    import skeleton_pass_scheduler_pkg::*;
#(
    parameter int H_COUNT    = 320,
    parameter int V_COUNT    = 180,
    parameter int MAX_PASSES = 32
);
    localparam int HW = cnt_width(H_COUNT);
    localparam int VW = cnt_width(V_COUNT);
    localparam int AW = addr_width(H_COUNT, V_COUNT);
    localparam int PW = cnt_width(MAX_PASSES + 1);

    logic          start_in;
    logic          change_in;
    logic [AW-1:0] rd_addr_out;
    logic [HW-1:0] scan_hcount_out;
    logic [VW-1:0] scan_vcount_out;
    logic          scan_valid_out;
    logic          thin_active_out;
    logic          parity_out;
    logic [HW-1:0] out_hcount_out;
    logic [VW-1:0] out_vcount_out;
    logic          out_valid_out;
    logic [PW-1:0] pass_count_out;
    logic          converged_out;
    logic          busy_out;
    logic          done_out;

    modport master (
        input  start_in, change_in,
        output rd_addr_out, scan_hcount_out, scan_vcount_out, scan_valid_out,
               thin_active_out, parity_out, out_hcount_out, out_vcount_out,
               out_valid_out, pass_count_out, converged_out, busy_out, done_out
    );

    modport slave (
        output start_in, change_in,
        input  rd_addr_out, scan_hcount_out, scan_vcount_out, scan_valid_out,
               thin_active_out, parity_out, out_hcount_out, out_vcount_out,
               out_valid_out, pass_count_out, converged_out, busy_out, done_out
    );

endinterface

// File: rtl/skeleton_pass_scheduler_raster_counter.sv
// Raster position counter: h runs 0..H_COUNT-1, v advances on each line wrap,
// and the whole frame wraps back to (0,0) after the last pixel.
module raster_counter
    import skeleton_pass_scheduler_pkg::*;
#(
    parameter int  H_COUNT = 320,
    parameter int  V_COUNT = 180,
    localparam int HW      = cnt_width(H_COUNT),
    localparam int VW      = cnt_width(V_COUNT)
) (
    input  logic          i_clk,
    input  logic          i_srst,
    input  logic          i_en,
    input  logic          i_clear,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_last
);
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_end;
    logic          w_v_end;

    assign w_h_end = (r_h == HW'(H_COUNT - 1));
    assign w_v_end = (r_v == VW'(V_COUNT - 1));

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clear) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_en) begin
            if (w_h_end) begin
                r_h <= '0;
                r_v <= w_v_end ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign o_h    = r_h;
    assign o_v    = r_v;
    assign o_last = w_h_end && w_v_end;

endmodule

// File: rtl/skeleton_pass_scheduler.sv
// Sequences alternating-parity thinning passes over the frame buffer until a
// pass deletes nothing (or the pass cap is hit), then streams a read-out scan.
module skeleton_pass_scheduler
    import skeleton_pass_scheduler_pkg::*;
#(
    parameter int H_COUNT      = 320,
    parameter int V_COUNT      = 180,
    parameter int PIPE_LATENCY = 4,
    parameter int RD_LATENCY   = 2,
    parameter int MAX_PASSES   = 32
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    skeleton_pass_scheduler_if.master   bus
);
    localparam int HW  = cnt_width(H_COUNT);
    localparam int VW  = cnt_width(V_COUNT);
    localparam int AW  = addr_width(H_COUNT, V_COUNT);
    localparam int PW  = cnt_width(MAX_PASSES + 1);
    localparam int DW  = cnt_width(PIPE_LATENCY);
    localparam int RW  = cnt_width(RD_LATENCY);
    localparam int TW  = 1 + HW + VW;

    logic [2:0]    r_state;
    logic          r_reading;
    logic          r_flag;
    logic          r_parity;
    logic          r_converged;
    logic          r_done;
    logic [PW-1:0] r_pass_count;
    logic [DW-1:0] r_drain_cnt;
    logic [RW-1:0] r_wait_cnt;
    logic [AW-1:0] r_rd_addr;

    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic          w_last;
    logic          w_cnt_en;
    logic          w_cnt_clear;
    logic [PW-1:0] w_pass_inc;
    logic [TW-1:0] w_rd_tag;
    logic [TW-1:0] w_out_tag;

    assign w_cnt_en    = (r_state == ST_SCAN) || ((r_state == ST_OUTPUT) && r_reading);
    assign w_cnt_clear = (r_state == ST_IDLE);
    assign w_pass_inc  = (r_pass_count == PW'(MAX_PASSES)) ? r_pass_count : r_pass_count + 1'b1;

    raster_counter #(
        .H_COUNT (H_COUNT),
        .V_COUNT (V_COUNT)
    ) u_raster (
        .i_clk   (clk_in),
        .i_srst  (rst_in),
        .i_en    (w_cnt_en),
        .i_clear (w_cnt_clear),
        .o_h     (w_h),
        .o_v     (w_v),
        .o_last  (w_last)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_reading    <= 1'b0;
            r_flag       <= 1'b0;
            r_parity     <= 1'b0;
            r_converged  <= 1'b0;
            r_done       <= 1'b0;
            r_pass_count <= '0;
            r_drain_cnt  <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        r_state      <= ST_SCAN;
                        r_parity     <= 1'b0;
                        r_flag       <= 1'b0;
                        r_pass_count <= '0;
                        r_converged  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_flag <= r_flag | bus.change_in;
                    if (w_last) begin
                        r_state     <= (PIPE_LATENCY == 0) ? ST_DECIDE : ST_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Deletions from the last scanned pixels still land here.
                    r_flag <= r_flag | bus.change_in;
                    if (r_drain_cnt == DW'(PIPE_LATENCY - 1)) begin
                        r_state <= ST_DECIDE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    r_pass_count <= w_pass_inc;
                    if (r_flag && (w_pass_inc < PW'(MAX_PASSES))) begin
                        r_parity <= ~r_parity;
                        r_flag   <= 1'b0;
                        r_state  <= ST_SCAN;
                    end else begin
                        r_converged <= ~r_flag;
                        r_reading   <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (r_reading) begin
                        if (w_last) begin
                            r_reading <= 1'b0;
                            if (RD_LATENCY == 0) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end
                        end
                    end else if (r_wait_cnt == RW'(RD_LATENCY - 1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Address tracks the raster counter incrementally, so it equals v*H_COUNT+h.
    always_ff @(posedge clk_in) begin
        if (rst_in || w_cnt_clear) begin
            r_rd_addr <= '0;
        end else if (w_cnt_en) begin
            r_rd_addr <= w_last ? '0 : r_rd_addr + 1'b1;
        end
    end

    assign w_rd_tag = {(r_state == ST_OUTPUT) && r_reading, w_h, w_v};

    generate
        if (RD_LATENCY == 0) begin : g_no_dly
            assign w_out_tag = w_rd_tag;
        end else begin : g_dly
            for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
                logic [TW-1:0] r_tag;
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk_in) begin
                        if (rst_in) r_tag <= '0;
                        else        r_tag <= w_rd_tag;
                    end
                end else begin : g_tail
                    always_ff @(posedge clk_in) begin
                        if (rst_in) r_tag <= '0;
                        else        r_tag <= g_stage[gi-1].r_tag;
                    end
                end
            end
            assign w_out_tag = g_stage[RD_LATENCY-1].r_tag;
        end
    endgenerate

    assign bus.rd_addr_out     = r_rd_addr;
    assign bus.scan_hcount_out = w_h;
    assign bus.scan_vcount_out = w_v;
    assign bus.scan_valid_out  = (r_state == ST_SCAN);
    assign bus.thin_active_out = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
    assign bus.parity_out      = r_parity;
    assign bus.out_valid_out   = w_out_tag[TW-1];
    assign bus.out_hcount_out  = w_out_tag[HW+VW-1:VW];
    assign bus.out_vcount_out  = w_out_tag[VW-1:0];
    assign bus.pass_count_out  = r_pass_count;
    assign bus.converged_out   = r_converged;
    assign bus.busy_out        = (r_state != ST_IDLE);
    assign bus.done_out        = r_done;

endmodule

// File: tb/tb_skeleton_pass_scheduler.sv
// Directed bench for skeleton_pass_scheduler on an 8x4 frame with short latencies.
module tb_skeleton_pass_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    skeleton_pass_scheduler_if #(.H_COUNT(8), .V_COUNT(4), .MAX_PASSES(4)) bus ();

    skeleton_pass_scheduler #(
        .H_COUNT(8), .V_COUNT(4), .PIPE_LATENCY(3), .RD_LATENCY(2), .MAX_PASSES(4)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered by run_job, checked by the scenario tasks.
    int j_passes, j_addr_err, j_beats, j_beat_err, j_first_valid;
    int j_done_cnt, j_done_idx, j_total_busy, j_post_busy, j_timeout;
    int j_scan_cyc [8];
    int j_drain_cyc[8];
    int j_par      [8];

    // mode 0: no change, 1: one change mid pass-0 scan, 2: change in last drain
    // cycle of pass 0, 3: change always, 4: no change but start during read-out
    task automatic run_job(input int mode);
        int  cyc, scan_idx, drain_idx, tail, post;
        bit  prev_sv, done_seen;
        j_passes = 0; j_addr_err = 0; j_beats = 0; j_beat_err = 0; j_first_valid = -1;
        j_done_cnt = 0; j_done_idx = -1; j_total_busy = 0; j_post_busy = 0; j_timeout = 0;
        for (int i = 0; i < 8; i++) begin
            j_scan_cyc[i] = 0; j_drain_cyc[i] = 0; j_par[i] = 0;
        end
        scan_idx = 0; drain_idx = 0; tail = 0; post = 0; prev_sv = 0; done_seen = 0;
        @(negedge clk);
        bus.start_in  = 1'b1;
        bus.change_in = (mode == 3);
        @(negedge clk);
        cyc = 0;
        while (cyc < 2000) begin
            bus.start_in  = 1'b0;
            bus.change_in = (mode == 3);
            if (bus.scan_valid_out) begin
                if (!prev_sv) begin
                    j_passes++;
                    scan_idx = 0; drain_idx = 0;
                    if (j_passes <= 8) j_par[j_passes-1] = int'(bus.parity_out);
                end
                if (bus.rd_addr_out != scan_idx || bus.scan_hcount_out != scan_idx % 8 ||
                    bus.scan_vcount_out != scan_idx / 8) j_addr_err++;
                if (j_passes <= 8) j_scan_cyc[j_passes-1]++;
                if (mode == 1 && j_passes == 1 && scan_idx == 10) bus.change_in = 1'b1;
                scan_idx++;
                tail = 0;
            end else if (bus.thin_active_out) begin
                if (j_passes >= 1 && j_passes <= 8) j_drain_cyc[j_passes-1]++;
                if (mode == 2 && j_passes == 1 && drain_idx == 2) bus.change_in = 1'b1;
                drain_idx++;
                tail = 0;
            end else if (bus.busy_out) begin
                if (mode == 4 && tail == 10) bus.start_in = 1'b1;
                tail++;
            end
            if (bus.out_valid_out) begin
                if (j_beats == 0) j_first_valid = cyc;
                if (bus.out_hcount_out != j_beats % 8 || bus.out_vcount_out != j_beats / 8) j_beat_err++;
                j_beats++;
            end
            if (bus.busy_out) j_total_busy++;
            if (bus.done_out) begin
                j_done_cnt++;
                if (!done_seen) j_done_idx = cyc;
                done_seen = 1;
            end else if (done_seen) begin
                post++;
                if (bus.busy_out) j_post_busy++;
            end
            prev_sv = bus.scan_valid_out;
            if (post >= 5) break;
            @(negedge clk);
            cyc++;
        end
        bus.start_in  = 1'b0;
        bus.change_in = 1'b0;
        if (!done_seen) j_timeout = 1;
        $display("job mode %0d: passes=%0d beats=%0d done_idx=%0d pass_count=%0d converged=%0d",
                 mode, j_passes, j_beats, j_done_idx, bus.pass_count_out, bus.converged_out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_in  = 1'b1;
        bus.change_in = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.busy_out !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy_out); end
        n_vec++; if (bus.scan_valid_out !== 1'b0 || bus.thin_active_out !== 1'b0) begin n_err++;
            $display("FAIL rst_scan got %b%b want 00", bus.scan_valid_out, bus.thin_active_out); end
        n_vec++; if (bus.rd_addr_out !== 5'd0 || bus.scan_hcount_out !== 3'd0 || bus.scan_vcount_out !== 2'd0) begin n_err++;
            $display("FAIL rst_addr got %0d/%0d/%0d want 0/0/0", bus.rd_addr_out, bus.scan_hcount_out, bus.scan_vcount_out); end
        n_vec++; if ({bus.out_valid_out, bus.out_hcount_out, bus.out_vcount_out} !== 6'd0) begin n_err++;
            $display("FAIL rst_out got %b want 0", {bus.out_valid_out, bus.out_hcount_out, bus.out_vcount_out}); end
        n_vec++; if ({bus.parity_out, bus.pass_count_out, bus.converged_out, bus.done_out} !== 6'd0) begin n_err++;
            $display("FAIL rst_status got %b want 0", {bus.parity_out, bus.pass_count_out, bus.converged_out, bus.done_out}); end
        rst = 1'b0;
        bus.start_in  = 1'b0;
        bus.change_in = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.busy_out !== 1'b0) begin n_err++; $display("FAIL rst_start_ignored busy got %b want 0", bus.busy_out); end
        $display("reset: applied");
    endtask

    task automatic test_no_change();
        run_job(0);
        n_vec++; if (j_timeout !== 0) begin n_err++; $display("FAIL nochg_timeout got %0d want 0", j_timeout); end
        n_vec++; if (j_passes !== 1) begin n_err++; $display("FAIL nochg_passes got %0d want 1", j_passes); end
        n_vec++; if (j_scan_cyc[0] !== 32) begin n_err++; $display("FAIL nochg_scan_cycles got %0d want 32", j_scan_cyc[0]); end
        n_vec++; if (j_drain_cyc[0] !== 3) begin n_err++; $display("FAIL nochg_drain_cycles got %0d want 3", j_drain_cyc[0]); end
        n_vec++; if (j_addr_err !== 0) begin n_err++; $display("FAIL nochg_addr_seq got %0d errors want 0", j_addr_err); end
        n_vec++; if (j_par[0] !== 0) begin n_err++; $display("FAIL nochg_parity got %0d want 0", j_par[0]); end
        n_vec++; if (j_beats !== 32 || j_beat_err !== 0) begin n_err++;
            $display("FAIL nochg_beats got %0d beats %0d errors want 32/0", j_beats, j_beat_err); end
        n_vec++; if (j_first_valid !== 38) begin n_err++; $display("FAIL nochg_first_valid got %0d want 38", j_first_valid); end
        n_vec++; if (j_done_idx !== 70 || j_total_busy !== 70) begin n_err++;
            $display("FAIL nochg_done got idx %0d busy %0d want 70/70", j_done_idx, j_total_busy); end
        n_vec++; if (j_done_cnt !== 1) begin n_err++; $display("FAIL nochg_done_count got %0d want 1", j_done_cnt); end
        n_vec++; if (bus.pass_count_out !== 3'd1 || bus.converged_out !== 1'b1) begin n_err++;
            $display("FAIL nochg_status got %0d/%b want 1/1", bus.pass_count_out, bus.converged_out); end
    endtask

    task automatic test_one_change();
        run_job(1);
        n_vec++; if (j_passes !== 2 || j_timeout !== 0) begin n_err++; $display("FAIL onechg_passes got %0d want 2", j_passes); end
        n_vec++; if (j_par[0] !== 0 || j_par[1] !== 1) begin n_err++;
            $display("FAIL onechg_parity got %0d,%0d want 0,1", j_par[0], j_par[1]); end
        n_vec++; if (j_scan_cyc[1] !== 32 || j_addr_err !== 0) begin n_err++;
            $display("FAIL onechg_addr got %0d cycles %0d errors want 32/0", j_scan_cyc[1], j_addr_err); end
        n_vec++; if (j_total_busy !== 106 || j_beats !== 32) begin n_err++;
            $display("FAIL onechg_timing got busy %0d beats %0d want 106/32", j_total_busy, j_beats); end
        n_vec++; if (bus.pass_count_out !== 3'd2 || bus.converged_out !== 1'b1) begin n_err++;
            $display("FAIL onechg_status got %0d/%b want 2/1", bus.pass_count_out, bus.converged_out); end
    endtask

    task automatic test_drain_capture();
        run_job(2);
        n_vec++; if (j_passes !== 2 || j_timeout !== 0) begin n_err++; $display("FAIL drain_passes got %0d want 2", j_passes); end
        n_vec++; if (j_drain_cyc[1] !== 3) begin n_err++; $display("FAIL drain_cycles got %0d want 3", j_drain_cyc[1]); end
        n_vec++; if (bus.pass_count_out !== 3'd2 || bus.converged_out !== 1'b1) begin n_err++;
            $display("FAIL drain_status got %0d/%b want 2/1", bus.pass_count_out, bus.converged_out); end
    endtask

    task automatic test_cap();
        run_job(3);
        n_vec++; if (j_passes !== 4 || j_timeout !== 0) begin n_err++; $display("FAIL cap_passes got %0d want 4", j_passes); end
        n_vec++; if (j_par[2] !== 0 || j_par[3] !== 1) begin n_err++;
            $display("FAIL cap_parity got %0d,%0d want 0,1", j_par[2], j_par[3]); end
        n_vec++; if (j_done_idx !== 178 || j_beats !== 32 || j_beat_err !== 0) begin n_err++;
            $display("FAIL cap_readout got idx %0d beats %0d err %0d want 178/32/0", j_done_idx, j_beats, j_beat_err); end
        n_vec++; if (bus.pass_count_out !== 3'd4 || bus.converged_out !== 1'b0) begin n_err++;
            $display("FAIL cap_status got %0d/%b want 4/0", bus.pass_count_out, bus.converged_out); end
    endtask

    task automatic test_start_during_output();
        run_job(4);
        n_vec++; if (j_done_cnt !== 1 || j_timeout !== 0) begin n_err++; $display("FAIL busystart_done got %0d want 1", j_done_cnt); end
        n_vec++; if (j_post_busy !== 0 || j_total_busy !== 70) begin n_err++;
            $display("FAIL busystart_busy got post %0d total %0d want 0/70", j_post_busy, j_total_busy); end
    endtask

    task automatic test_reset_mid_scan();
        int  guard, dones, busys;
        @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        guard = 0;
        while (!(bus.scan_valid_out && bus.scan_hcount_out == 3'd5 && bus.scan_vcount_out == 2'd2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++; if (guard >= 100 || bus.rd_addr_out !== 5'd21) begin n_err++;
            $display("FAIL midrst_addr got %0d (wait %0d) want 21", bus.rd_addr_out, guard); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (bus.busy_out !== 1'b0 || bus.scan_valid_out !== 1'b0 || bus.done_out !== 1'b0) begin n_err++;
            $display("FAIL midrst_idle got busy %b scan %b done %b want 000", bus.busy_out, bus.scan_valid_out, bus.done_out); end
        n_vec++; if (bus.rd_addr_out !== 5'd0 || bus.pass_count_out !== 3'd0) begin n_err++;
            $display("FAIL midrst_clear got addr %0d pass %0d want 0/0", bus.rd_addr_out, bus.pass_count_out); end
        dones = 0; busys = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done_out) dones++;
            if (bus.busy_out) busys++;
        end
        n_vec++; if (dones !== 0 || busys !== 0) begin n_err++;
            $display("FAIL midrst_quiet got done %0d busy %0d want 0/0", dones, busys); end
        $display("reset mid-scan: applied");
    endtask

    initial begin
        bus.start_in  = 1'b0;
        bus.change_in = 1'b0;
        test_reset();
        test_no_change();
        test_one_change();
        test_drain_capture();
        test_cap();
        test_start_during_output();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
